// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  // Refill controller states.
  typedef enum logic [1:0] {
    StIdle,
    StRequest,
    StRefill
  } icache_state_t;

  // Canonical NOP (addi x0, x0, 0); also used by decode.
  localparam logic [31:0] IcacheNop = 32'h0000_0013;

  // Field widths of a fetch address: [tag | index | offset | byte].
  function automatic int unsigned offset_width(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned index_width(input int unsigned line_count);
    return $clog2(line_count);
  endfunction

  function automatic int unsigned tag_width(input int unsigned line_count,
                                            input int unsigned words_per_line);
    return 32 - 2 - $clog2(line_count) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction data storage: one asynchronous read port, one synchronous write port.
module icache_data_array #(
  parameter int unsigned LineCount    = 16,
  parameter int unsigned WordsPerLine = 4
) (
  input  logic                            clk_i,
  input  logic [$clog2(LineCount)-1:0]    rd_index_i,
  input  logic [$clog2(WordsPerLine)-1:0] rd_offset_i,
  output logic [31:0]                     rd_data_o,
  input  logic                            wr_en_i,
  input  logic [$clog2(LineCount)-1:0]    wr_index_i,
  input  logic [$clog2(WordsPerLine)-1:0] wr_offset_i,
  input  logic [31:0]                     wr_data_i
);

  // Contents are never reset; the tag-side valid bits guard stale data.
  logic [31:0] r_mem [LineCount][WordsPerLine];

  assign rd_data_o = r_mem[rd_index_i][rd_offset_i];

  // Write one refill word per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_index_i][wr_offset_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a single-line refill engine.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LineCount      = 16,
  parameter int unsigned WordsPerLine   = 4,
  parameter logic [31:0] NopInstruction = IcacheNop
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] read_address_i,
  output logic [31:0] read_data_o,
  output logic        hit_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_address_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_data_i
);

  localparam int unsigned OffW    = offset_width(WordsPerLine);
  localparam int unsigned IdxW    = index_width(LineCount);
  localparam int unsigned TagW    = tag_width(LineCount, WordsPerLine);
  localparam int unsigned IdxLsb  = OffW + 2;
  localparam int unsigned TagLsb  = IdxLsb + IdxW;
  localparam logic [31:0] BaseMask = ~((32'd1 << IdxLsb) - 32'd1);

  // Address fields of the current fetch.
  logic [OffW-1:0] w_offset;
  logic [IdxW-1:0] w_index;
  logic [TagW-1:0] w_tag;
  logic            w_unused;

  assign w_offset = read_address_i[IdxLsb-1:2];
  assign w_index  = read_address_i[TagLsb-1:IdxLsb];
  assign w_tag    = read_address_i[31:TagLsb];
  assign w_unused = ^read_address_i[1:0];

  // Lookup state and refill bookkeeping.
  icache_state_t   r_state;
  icache_state_t   w_state_next;
  logic [LineCount-1:0] r_valid;
  logic [TagW-1:0] r_tag [LineCount];
  logic [OffW-1:0] r_count;
  logic [31:0]     r_base;
  logic [IdxW-1:0] r_index;

  logic            w_hit;
  logic [31:0]     w_rd_data;
  logic            w_req_valid;
  logic            w_start;
  logic            w_fill_we;
  logic            w_fill_last;

  icache_data_array #(
    .LineCount    (LineCount),
    .WordsPerLine (WordsPerLine)
  ) u_data_array (
    .clk_i       (clk_i),
    .rd_index_i  (w_index),
    .rd_offset_i (w_offset),
    .rd_data_o   (w_rd_data),
    .wr_en_i     (w_fill_we),
    .wr_index_i  (r_index),
    .wr_offset_i (r_count),
    .wr_data_i   (mem_resp_data_i)
  );

  // Hit is evaluated in every state so other lines keep serving during a refill.
  assign w_hit             = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign hit_o             = w_hit;
  assign read_data_o       = w_hit ? w_rd_data : NopInstruction;
  assign mem_req_valid_o   = w_req_valid;
  assign mem_req_address_o = r_base;

  // Next-state and refill control decode.
  always_comb begin
    w_state_next = r_state;
    w_req_valid  = 1'b0;
    w_start      = 1'b0;
    w_fill_we    = 1'b0;
    w_fill_last  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_hit) begin
          w_start      = 1'b1;
          w_state_next = StRequest;
        end
      end
      StRequest: begin
        w_req_valid = 1'b1;
        if (mem_req_ready_i) begin
          w_state_next = StRefill;
        end
      end
      StRefill: begin
        if (mem_resp_valid_i) begin
          w_fill_we = 1'b1;
          if (&r_count) begin
            w_fill_last  = 1'b1;
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Valid bits, latched refill target and word counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_count <= '0;
      r_base  <= '0;
      r_index <= '0;
    end else begin
      if (w_start) begin
        r_base           <= read_address_i & BaseMask;
        r_index          <= w_index;
        r_valid[w_index] <= 1'b0;
      end
      if (r_state == StRequest && mem_req_ready_i) begin
        r_count <= '0;
      end
      if (w_fill_we) begin
        r_count <= r_count + 1'b1;
      end
      if (w_fill_last) begin
        r_valid[r_index] <= 1'b1;
      end
    end
  end

  // Tag store; written together with the final refill word, never reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_fill_last) begin
      r_tag[r_index] <= r_base[31:TagLsb];
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for the instruction cache.
module tb_icache;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        hit;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_accept = 0;

  icache #(
    .LineCount      (16),
    .WordsPerLine   (4),
    .NopInstruction (Nop)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .read_address_i    (rd_addr),
    .read_data_o       (rd_data),
    .hit_o             (hit),
    .mem_req_valid_o   (req_valid),
    .mem_req_ready_i   (req_ready),
    .mem_req_address_o (req_addr),
    .mem_resp_valid_i  (resp_valid),
    .mem_resp_data_i   (resp_data)
  );

  always #5 clk = ~clk;

  // Count request handshakes.
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) n_accept <= n_accept + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full miss/refill with ready=1 and back-to-back responses d0..d0+3.
  task automatic do_fill(input logic [31:0] addr, input logic [31:0] d0);
    rd_addr    = addr;
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    #1;
    check("fill_miss", hit, 0);
    check("fill_nop", rd_data, Nop);
    check("fill_idle_noreq", req_valid, 0);
    cyc();
    #1;
    check("fill_req_valid", req_valid, 1);
    check("fill_req_addr", req_addr, addr & 32'hFFFF_FFF0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      resp_valid = 1'b1;
      resp_data  = d0 + i;
    end
    cyc();
    resp_valid = 1'b0;
    #1;
    check("fill_hit", hit, 1);
    check("fill_data", rd_data, d0 + addr[3:2]);
  endtask

  initial begin
    int a0;
    rst = 1'b1; rd_addr = '0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    cyc();
    cyc();
    #1;
    check("rst_hit", hit, 0);
    check("rst_data", rd_data, Nop);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, 0);
    rst = 1'b0;

    // Cold miss on 0x0, hit in cycle 6.
    do_fill(32'h0, 32'hA0);
    rd_addr = 32'hC; #1;
    check("s1_hit_c", hit, 1);
    check("s1_data_c", rd_data, 32'hA3);

    // Miss on 0x104 with ready held low for 5 request cycles.
    rd_addr = 32'h104; req_ready = 1'b0; #1;
    check("s2_miss", hit, 0);
    cyc();
    a0 = n_accept;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("s2_hold_valid", req_valid, 1);
      check("s2_hold_addr", req_addr, 32'h100);
      cyc();
    end
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    #1;
    check("s2_req_dropped", req_valid, 0);
    check("s2_accept_once", n_accept - a0, 1);
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1'b1;
      resp_data  = 32'hB0 + i;
      cyc();
    end
    resp_valid = 1'b0;
    #1;
    check("s2_hit", hit, 1);
    check("s2_data", rd_data, 32'hB1);
    rd_addr = 32'h10C; #1;
    check("s2_idx0_data", rd_data, 32'hB3);

    // Conflicts on index 0: 0x000 misses, then 0x100 misses, then 0x000 again.
    do_fill(32'h000, 32'hC0);
    do_fill(32'h100, 32'hD0);
    do_fill(32'h008, 32'hC8);

    // Fill index 1, then gapped refill of index 2 while fetching from index 1.
    do_fill(32'h010, 32'hE0);
    rd_addr = 32'h020; #1;
    check("s4_miss", hit, 0);
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1'b1;
      resp_data  = 32'hF00 + i;
      if (i == 1) rd_addr = 32'h014;
      #1;
      if (i == 0) check("s4_refill_line_miss", hit, 0);
      else        check("s4_old_line_data", rd_data, 32'hE1);
      cyc();
      resp_valid = 1'b0;
      #1;
      check("s4_gap_hit", hit, (i == 0) ? 0 : 1);
      cyc();
    end
    rd_addr = 32'h020; #1;
    check("s4_new_w0", rd_data, 32'hF00);
    rd_addr = 32'h02C; #1;
    check("s4_new_w3", rd_data, 32'hF03);
    check("s4_new_hit", hit, 1);

    // Reset after two refill words.
    rd_addr = 32'h030; #1;
    check("s5_miss", hit, 0);
    cyc();
    cyc();
    resp_valid = 1'b1; resp_data = 32'h3A0;
    cyc();
    resp_data = 32'h3A1;
    cyc();
    resp_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("s5_rst_hit", hit, 0);
    check("s5_rst_data", rd_data, Nop);
    check("s5_rst_req", req_valid, 0);
    check("s5_rst_addr", req_addr, 0);
    rd_addr = 32'h014; #1;
    check("s5_old_invalid", hit, 0);
    do_fill(32'h030, 32'h300);

    // Spurious responses in IDLE.
    rd_addr = 32'h034; resp_valid = 1'b1; resp_data = 32'hDEAD;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("s6_idle_data", rd_data, 32'h301);
      check("s6_idle_noreq", req_valid, 0);
      cyc();
    end
    resp_valid = 1'b0;

    // Spurious responses in REQUEST and in the acceptance cycle.
    rd_addr = 32'h040; req_ready = 1'b0; #1;
    check("s6_miss", hit, 0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      resp_valid = 1'b1; resp_data = 32'hDEAD;
      #1;
      check("s6_req_valid", req_valid, 1);
      check("s6_req_addr", req_addr, 32'h040);
      cyc();
    end
    req_ready = 1'b1; resp_data = 32'hBAD;
    cyc();
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1'b1;
      resp_data  = 32'h400 + i;
      cyc();
    end
    resp_valid = 1'b0;
    #1;
    check("s6_w0", rd_data, 32'h400);
    rd_addr = 32'h04C; #1;
    check("s6_w3", rd_data, 32'h403);
    rd_addr = 32'h034; #1;
    check("s6_old_line", rd_data, 32'h301);
    check("s6_old_hit", hit, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
